led_mode_controller: RTL and testbench
======================================

// Module: led_mode_controller
// PURPOSE
//   Sequences LED1 through a set of display modes from one debounced push-button.
//   Classifies each press as short or long by hold time, advances a mode FSM and
//   generates the LED drive (off / on / slow blink / fast blink).
//   Sits between the button Debounce instance and the LED1 pin.
//   Replaces the plain toggle-on-falling-edge logic.
// PARAMETERS
//   LONG_PRESS_CYCLES  100_000_000  consecutive low samples that qualify a long press (>=2)
//   SLOW_HALF_CYCLES   25_000_000   half-period of slow blink, in clocks (>=1)
//   FAST_HALF_CYCLES   5_000_000    half-period of fast blink, in clocks (>=1)
// PORTS
//   CLK      in   1  system clock; all logic on posedge
//   RST_N    in   1  asynchronous active-low reset
//   i_BUT1   in   1  debounced button; synchronous to CLK; 0 = pressed, 1 = released
//   LED1     out  1  LED drive, registered
//   o_MODE   out  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST
//   o_SHORT  out  1  one-cycle pulse on each short press
//   o_LONG   out  1  one-cycle pulse on each long press
// BEHAVIOUR
//   Reset (async assert, sync release)
//     o_MODE=OFF, LED1=0, o_SHORT=0, o_LONG=0, hold/blink counters=0.
//     but_prev=1 (released), long_done=0.
//   Edge detect
//     but_prev <= i_BUT1 every cycle.
//     Press = i_BUT1==0 && but_prev==1; release = i_BUT1==1 && but_prev==0.
//     A button held low across reset release is a press starting on the first post-reset cycle.
//   Hold counter (ceil(log2(LONG_PRESS_CYCLES+1)) bits)
//     On press: set to 1.
//     While i_BUT1==0 after the press: increment, saturating at LONG_PRESS_CYCLES.
//     On release: clear to 0.
//   Long press
//     On the edge where the count becomes LONG_PRESS_CYCLES: o_LONG=1 for that one cycle,
//     o_MODE<=OFF, long_done<=1. This fires while the button is still held.
//     The release that follows produces no event and clears long_done.
//   Short press
//     Release with long_done==0 (count < LONG_PRESS_CYCLES): on the same edge o_SHORT=1
//     for one cycle and o_MODE advances OFF->ON->SLOW->FAST->OFF (wraps).
//   Simultaneous events
//     Only one event per press; press and release cannot occur in the same cycle.
//     A press in the cycle directly after a release starts a new hold at 1.
//   Blink generator
//     Counter and phase are cleared on every o_MODE change. Phase=1 on entry.
//     SLOW: phase toggles after SLOW_HALF_CYCLES clocks in the mode, then every
//     SLOW_HALF_CYCLES; the counter wraps at HALF-1. FAST: identical using FAST_HALF_CYCLES.
//   LED1
//     Registered, one cycle after o_MODE/phase: OFF->0, ON->1, SLOW/FAST->phase.
//   Reset mid-operation
//     Any hold or blink is abandoned; all state returns to reset values. No event pulses.
// TESTING (LONG_PRESS_CYCLES=8, SLOW_HALF=4, FAST_HALF=2)
//   Reset with i_BUT1=1 -> o_MODE=0, LED1=0, no pulses for 50 cycles.
//   Four presses, each 3 cycles low / 5 high -> four o_SHORT pulses.
//     o_MODE steps 1,2,3,0; LED1=1 one cycle after mode becomes 1.
//   Mode 2, no input -> LED1 pattern 1111 0000 1111 repeating (period 8), starting 1 cycle after entry.
//     Mode 3 -> 1100 repeating.
//   From mode 3, hold low 20 cycles -> o_LONG once, on the 8th low cycle.
//     o_MODE=0 the same edge; no o_SHORT on release.
//   Hold exactly 7 cycles -> o_SHORT (no o_LONG). Hold 8 -> o_LONG only.
//   Hold i_BUT1=0 through reset release for 10 cycles -> o_LONG at post-reset cycle 8.
//     Assert RST_N mid-blink -> LED1=0 and o_MODE=0 immediately (async).

Source files
------------

// File: rtl/led_mode_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_controller_if
// Description : Button-in / LED-and-status-out bundle of the LED mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_mode_controller_if;
   logic       i_BUT1;
   logic       LED1;
   logic [1:0] o_MODE;
   logic       o_SHORT;
   logic       o_LONG;

   modport master (output i_BUT1, input LED1, o_MODE, o_SHORT, o_LONG);
   modport slave  (input i_BUT1, output LED1, o_MODE, o_SHORT, o_LONG);
endinterface
`default_nettype wire

// File: rtl/led_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_controller
// Description : Short/long press classifier driving an OFF/ON/SLOW/FAST LED mode FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module led_mode_controller #(
   parameter int LONG_PRESS_CYCLES = 100_000_000,
   parameter int SLOW_HALF_CYCLES  = 25_000_000,
   parameter int FAST_HALF_CYCLES  = 5_000_000
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   led_mode_controller_if.slave  bus
);

   localparam int c_HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam int c_BLINK_MAX = (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ? SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
   localparam int c_BLINK_W   = $clog2(c_BLINK_MAX + 1);

   localparam logic [c_HOLD_W-1:0]  c_HOLD_MAX  = c_HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [c_HOLD_W-1:0]  c_HOLD_ONE  = c_HOLD_W'(1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_ONE = c_BLINK_W'(1);
   localparam logic [c_BLINK_W-1:0] c_SLOW_LAST = c_BLINK_W'(SLOW_HALF_CYCLES - 1);
   localparam logic [c_BLINK_W-1:0] c_FAST_LAST = c_BLINK_W'(FAST_HALF_CYCLES - 1);

   localparam logic [1:0] c_MODE_OFF  = 2'd0;
   localparam logic [1:0] c_MODE_ON   = 2'd1;
   localparam logic [1:0] c_MODE_SLOW = 2'd2;
   localparam logic [1:0] c_MODE_FAST = 2'd3;

   logic                 r_but_prev;
   logic [c_HOLD_W-1:0]  r_hold;
   logic [c_HOLD_W-1:0]  w_hold_next;
   logic                 r_long_done;
   logic [1:0]           r_mode;
   logic [1:0]           w_mode_next;
   logic                 r_short;
   logic                 r_long;
   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic [c_BLINK_W-1:0] w_half_last;
   logic                 r_phase;
   logic                 r_led;
   logic                 w_led_next;
   logic                 w_press;
   logic                 w_release;
   logic                 w_long_evt;
   logic                 w_short_evt;

   assign w_press     = !bus.i_BUT1 &&  r_but_prev;
   assign w_release   =  bus.i_BUT1 && !r_but_prev;
   // Fires only on the transition into saturation, so a long hold yields one pulse.
   assign w_long_evt  = !bus.i_BUT1 && (w_hold_next == c_HOLD_MAX) && (r_hold != c_HOLD_MAX);
   assign w_short_evt = w_release && !r_long_done;
   assign w_half_last = (r_mode == c_MODE_SLOW) ? c_SLOW_LAST : c_FAST_LAST;

   always_comb begin
      w_hold_next = r_hold;
      if (w_press) begin
         w_hold_next = c_HOLD_ONE;
      end else if (w_release) begin
         w_hold_next = '0;
      end else if (!bus.i_BUT1 && (r_hold != c_HOLD_MAX)) begin
         w_hold_next = r_hold + c_HOLD_ONE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_but_prev  <= 1'b1;
         r_hold      <= '0;
         r_long_done <= 1'b0;
         r_short     <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         r_but_prev <= bus.i_BUT1;
         r_hold     <= w_hold_next;
         r_short    <= w_short_evt;
         r_long     <= w_long_evt;
         if (w_release) begin
            r_long_done <= 1'b0;
         end else if (w_long_evt) begin
            r_long_done <= 1'b1;
         end
      end
   end

   // Mode FSM: state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mode <= c_MODE_OFF;
      end else begin
         r_mode <= w_mode_next;
      end
   end

   // Mode FSM: next state; FAST wraps to OFF through 2-bit overflow
   always_comb begin
      w_mode_next = r_mode;
      if (w_long_evt) begin
         w_mode_next = c_MODE_OFF;
      end else if (w_short_evt) begin
         w_mode_next = r_mode + 2'd1;
      end
   end

   // Mode FSM: output decode
   always_comb begin
      w_led_next = 1'b0;
      case (r_mode)
         c_MODE_OFF: w_led_next = 1'b0;
         c_MODE_ON:  w_led_next = 1'b1;
         default:    w_led_next = r_phase;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
         r_led       <= 1'b0;
      end else begin
         r_led <= w_led_next;
         if (w_mode_next != r_mode) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
         end else if ((r_mode == c_MODE_SLOW) || (r_mode == c_MODE_FAST)) begin
            if (r_blink_cnt == w_half_last) begin
               r_blink_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
            end
         end
      end
   end

   assign bus.LED1    = r_led;
   assign bus.o_MODE  = r_mode;
   assign bus.o_SHORT = r_short;
   assign bus.o_LONG  = r_long;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_mode_controller
// Description : Randomized scoreboard bench for led_mode_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_controller;

   localparam int c_LONG = 8;
   localparam int c_SLOW = 4;
   localparam int c_FAST = 2;

   typedef struct {
      logic [1:0] mode;
      logic       led;
   } exp_t;

   typedef struct {
      bit is_long;
      int edge_n;
   } ev_t;

   logic CLK;
   logic RST_N;
   led_mode_controller_if bus ();

   led_mode_controller #(
      .LONG_PRESS_CYCLES (c_LONG),
      .SLOW_HALF_CYCLES  (c_SLOW),
      .FAST_HALF_CYCLES  (c_FAST)
   ) u_dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   ev_t  ev_q[$];
   bit   mon_en = 1'b0;
   int   mon_edge = 0;

   // reference model state: low-run length and mode entry time
   int m_n     = 0;
   int m_run   = 0;
   int m_mode  = 0;
   int m_entry = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic bit led_of(input int mode, input int age);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ((age / c_SLOW) % 2) == 0;
         default: return ((age / c_FAST) % 2) == 0;
      endcase
   endfunction

   task automatic model_step(input bit b);
      exp_t e;
      ev_t  ev;
      m_n++;
      e.led = led_of(m_mode, m_n - 1 - m_entry);
      if (!b) begin
         m_run++;
         if (m_run == c_LONG) begin
            ev.is_long = 1'b1;
            ev.edge_n  = m_n;
            ev_q.push_back(ev);
            if (m_mode != 0) begin
               m_mode  = 0;
               m_entry = m_n;
            end
         end
      end else begin
         if (m_run > 0 && m_run < c_LONG) begin
            ev.is_long = 1'b0;
            ev.edge_n  = m_n;
            ev_q.push_back(ev);
            m_mode  = (m_mode + 1) % 4;
            m_entry = m_n;
         end
         m_run = 0;
      end
      e.mode = 2'(m_mode);
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit b);
      @(negedge CLK);
      bus.i_BUT1 = b;
      model_step(b);
   endtask

   task automatic release_reset(input bit b);
      @(negedge CLK);
      RST_N    = 1'b1;
      m_n      = 0;
      m_run    = 0;
      m_mode   = 0;
      m_entry  = 0;
      mon_edge = 0;
      exp_q.delete();
      ev_q.delete();
      mon_en     = 1'b1;
      bus.i_BUT1 = b;
      model_step(b);
   endtask

   task automatic press(input int lo, input int hi);
      repeat (lo) drive(1'b0);
      repeat (hi) drive(1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mode"},  32'(bus.o_MODE),  0);
      chk({tag, "_led"},   32'(bus.LED1),    0);
      chk({tag, "_short"}, 32'(bus.o_SHORT), 0);
      chk({tag, "_long"},  32'(bus.o_LONG),  0);
   endtask

   // monitor: per-cycle mode/LED and event pulses against the queued expectations
   exp_t mon_e;
   ev_t  mon_ev;
   always @(posedge CLK) begin
      #2;
      if (mon_en) begin
         mon_edge++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL exp_underflow: got empty queue expected entry at edge %0d", mon_edge);
         end else begin
            mon_e = exp_q.pop_front();
            chk("mode", 32'(bus.o_MODE), 32'(mon_e.mode));
            chk("led",  32'(bus.LED1),   32'(mon_e.led));
         end
         while (ev_q.size() > 0 && ev_q[0].edge_n < mon_edge) begin
            mon_ev = ev_q.pop_front();
            chk("missed_event_edge", 32'(mon_edge), 32'(mon_ev.edge_n));
         end
         if (bus.o_SHORT || bus.o_LONG) begin
            chk("pulse_exclusive", 32'(bus.o_SHORT & bus.o_LONG), 0);
            if (ev_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got short=%0d long=%0d expected none at edge %0d",
                        bus.o_SHORT, bus.o_LONG, mon_edge);
            end else begin
               mon_ev = ev_q.pop_front();
               chk("event_long", 32'(bus.o_LONG), 32'(mon_ev.is_long));
               chk("event_edge", 32'(mon_edge), 32'(mon_ev.edge_n));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned lo;
      int unsigned hi;
      RST_N      = 1'b0;
      bus.i_BUT1 = 1'b1;
      repeat (3) @(posedge CLK);
      #2;
      check_reset_outputs("reset");

      release_reset(1'b1);
      repeat (49) drive(1'b1);

      repeat (4) press(3, 5);
      press(3, 5);
      press(3, 24);
      press(3, 12);
      press(20, 6);
      press(7, 6);
      press(8, 6);

      for (int i = 0; i < 200; i++) begin
         lo = $urandom_range(1, 12);
         hi = $urandom_range(1, 12);
         press(int'(lo), int'(hi));
      end
      repeat (10) drive(1'b1);

      // enter SLOW, then reset asynchronously while LED is lit
      while (m_mode != 2) press(2, 1);
      drive(1'b1);
      @(posedge CLK);
      #4;
      RST_N  = 1'b0;
      mon_en = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      ev_q.delete();

      bus.i_BUT1 = 1'b0;
      repeat (3) @(posedge CLK);
      #2;
      check_reset_outputs("reset_held_low");
      release_reset(1'b0);
      repeat (9) drive(1'b0);
      repeat (10) drive(1'b1);

      @(posedge CLK);
      #4;
      mon_en = 1'b0;
      chk("exp_queue_left",   32'(exp_q.size()), 0);
      chk("event_queue_left", 32'(ev_q.size()),  0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
